pts_framed_tx: RTL and testbench
================================

# pts_framed_tx

Parameterized parallel-to-serial transmitter, the transmit end of the lab serial link whose receive end is the serial-to-parallel shift register. Captures a BIT_WIDTH-bit word on a load strobe, then emits a framed bit stream (start bit, data bits, stop bit) one bit per shift-enable pulse. Reports busy and a one-cycle done pulse. Sits between board switches/keys and the serial line feeding the receiver.

## Interface
- BIT_WIDTH, 4, number of data bits per frame (≥2).
- MSB_FIRST, 1, 1 = data sent MSB first; 0 = LSB first.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- shift_en  in  1  bit-time enable; each high cycle advances the line by one bit.
- load_en  in  1  load strobe; accepted only when busy = 0.
- par_in  in  BIT_WIDTH  word to transmit, sampled on the accepting edge.
- ser_out  out  1  serial line, registered, idles high.
- busy  out  1  high from the accepting edge until the stop bit completes.
- done  out  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: ser_out = 1, busy = 0. load_en = 1 → capture par_in into shift register, clear bit counter, go to START.
- START: ser_out = 0. On shift_en → go to DATA, drive first data bit.
- DATA: ser_out = current data bit. On shift_en: if counter = BIT_WIDTH-1 → go to STOP; else shift and increment counter.
- STOP: ser_out = 1. On shift_en → assert done for one cycle, go to IDLE.
- Without shift_en, state, counter and ser_out hold indefinitely.
- load_en while busy = 1: ignored; captured word unchanged.
- load_en and shift_en both high in IDLE: load accepted; shift_en ignored that cycle (START lasts at least until the next shift_en).
- Bit order: MSB_FIRST = 1 sends par_in[BIT_WIDTH-1] first; 0 sends par_in[0] first.
- Counter width: $clog2(BIT_WIDTH); no wrap beyond BIT_WIDTH-1.
- par_in changes after capture have no effect on the frame in flight.

## Timing
- Reset (n_rst low, any time, asynchronous): state IDLE, ser_out = 1, busy = 0, done = 0, shift register = 0, counter = 0. Frame in flight is abandoned; line returns high immediately.
- Load accepted at edge k: busy = 1 and ser_out = 0 after edge k.
- With shift_en held high from edge k+1: data bit i is on ser_out after edge k+1+i; stop bit after edge k+1+BIT_WIDTH; done = 1 and busy = 0 after edge k+2+BIT_WIDTH, for one cycle.
- Frame length: BIT_WIDTH+2 bit times (start + data + stop); minimum BIT_WIDTH+3 clock cycles load-to-idle.
- Back-to-back: the next load is accepted on any edge where busy = 0, including the cycle done = 1.
- All outputs registered; no combinational input-to-output path.

## Structure
- Package pts_pkg: typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}; localparam IDLE_LEVEL = 1'b1, START_LEVEL = 1'b0.
- One sub-module: flex_bit_counter (parameter NUM_BITS, inputs clk, n_rst, clear, count_en, rollover_val; output rollover_flag), used for the data-bit count.
- Shift register, FSM next-state and output logic live in pts_framed_tx.

## Test plan
- Reset: n_rst low mid-operation → ser_out = 1, busy = 0, done = 0 within the same cycle, without waiting for a clock edge; after release, the line stays high with no loads.
- BIT_WIDTH=4, MSB_FIRST=1, par_in = 4'b1101, shift_en constant high → ser_out 0,1,1,0,1,1; done pulses once 6 cycles after load; busy low after done.
- MSB_FIRST=0, par_in = 4'b1101 → ser_out 0,1,0,1,1,1.
- Load 4'b1010, then pulse load_en with par_in = 4'b0101 during DATA → transmitted data stays 1,0,1,0; second load ignored.
- shift_en high only every 3rd cycle → each bit held exactly 3 cycles; frame spans 18 cycles; done a single-cycle pulse.
- Loopback: data-bit window of ser_out fed to the serial-to-parallel receiver → received parallel word equals par_in for all 16 4-bit values, loads issued back-to-back on the done cycle.

Source files
------------

// File: rtl/pts_pkg.sv
// Shared types and line levels for the framed parallel-to-serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pts_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Line level while idle and during the stop bit, and the start-bit level.
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/flex_bit_counter.sv
// Counts enabled cycles from 0 up to rollover_val, then returns to 0.
// Latency: count updates one cycle after count_en; rollover_flag follows the count combinationally.
// Backpressure: none; count holds whenever count_en is low.
// Ports: clk, n_rst (async active-low), clear (sync, wins over count_en),
//        count_en, rollover_val (terminal count), rollover_flag (count == rollover_val).
module flex_bit_counter #(
  parameter int NUM_BITS = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_en,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic                rollover_flag
);

  logic [NUM_BITS-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      // Never runs past the terminal value.
      count <= (count == rollover_val) ? '0 : count + 1'b1;
    end
  end

  assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/pts_framed_tx.sv
// Framed parallel-to-serial transmitter: start bit, BIT_WIDTH data bits, stop bit.
// Latency: start bit on the line the cycle after load; one bit per shift_en pulse; done after the stop bit.
// Backpressure: load_en is ignored while busy; shift_en low holds the line and all state.
// Ports: clk, n_rst (async active-low), shift_en (bit-time enable), load_en (load strobe),
//        par_in (word to send), ser_out (registered line, idles high), busy, done (1-cycle pulse).
module pts_framed_tx
  import pts_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 shift_en,
  input  logic                 load_en,
  input  logic [BIT_WIDTH-1:0] par_in,
  output logic                 ser_out,
  output logic                 busy,
  output logic                 done
);

  localparam int             CNT_W    = $clog2(BIT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

  tx_state_t            state;
  logic [BIT_WIDTH-1:0] shreg;
  logic [BIT_WIDTH-1:0] shreg_next;
  logic                 head_bit;
  logic                 next_bit;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic                 last_bit;

  // The bit to be sent next always sits at the outgoing end of shreg.
  assign head_bit   = MSB_FIRST ? shreg[BIT_WIDTH-1] : shreg[0];
  assign shreg_next = MSB_FIRST ? {shreg[BIT_WIDTH-2:0], 1'b0}
                                : {1'b0, shreg[BIT_WIDTH-1:1]};
  assign next_bit   = MSB_FIRST ? shreg_next[BIT_WIDTH-1] : shreg_next[0];

  // Counter holds the index of the data bit currently on the line.
  assign cnt_clear = (state == IDLE) && load_en;
  assign cnt_en    = (state == DATA) && shift_en;

  flex_bit_counter #(
    .NUM_BITS(CNT_W)
  ) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_en     (cnt_en),
    .rollover_val (LAST_BIT),
    .rollover_flag(last_bit)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      shreg   <= '0;
      ser_out <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // shift_en in the load cycle is deliberately not acted on.
          if (load_en) begin
            shreg   <= par_in;
            state   <= START;
            ser_out <= START_LEVEL;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (shift_en) begin
            state   <= DATA;
            ser_out <= head_bit;
          end
        end
        DATA: begin
          if (shift_en) begin
            if (last_bit) begin
              state   <= STOP;
              ser_out <= IDLE_LEVEL;
            end else begin
              shreg   <= shreg_next;
              ser_out <= next_bit;
            end
          end
        end
        STOP: begin
          if (shift_en) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ser_out <= IDLE_LEVEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pts_framed_tx.sv
// Bench for pts_framed_tx: an MSB-first and an LSB-first instance share all inputs.
// Expected line values come from a frame model (start, ordered data bits, stop)
// indexed by the number of shift pulses seen since the load.
module tb_pts_framed_tx;

  logic       clk;
  logic       n_rst;
  logic       shift_en;
  logic       load_en;
  logic [3:0] par_in;
  logic       ser_m, busy_m, done_m;
  logic       ser_l, busy_l, done_l;

  int total = 0;
  int bad   = 0;

  pts_framed_tx #(.BIT_WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .n_rst(n_rst), .shift_en(shift_en), .load_en(load_en),
    .par_in(par_in), .ser_out(ser_m), .busy(busy_m), .done(done_m)
  );

  pts_framed_tx #(.BIT_WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .shift_en(shift_en), .load_en(load_en),
    .par_in(par_in), .ser_out(ser_l), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit s (s = shift pulses since load): 0 = start, 1..4 = data, 5 = stop.
  function automatic logic [5:0] frame_bits(input logic [3:0] w, input bit msb);
    logic [5:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 4; i++) f[1+i] = msb ? w[3-i] : w[i];
    f[5] = 1'b1;
    return f;
  endfunction

  // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic tick(input logic ld, input logic [3:0] w, input logic sh);
    load_en  = ld;
    par_in   = w;
    shift_en = sh;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] obs();
    return {ser_m, busy_m, done_m, ser_l, busy_l, done_l};
  endfunction

  task automatic test_reset();
    logic [5:0] o;
    @(negedge clk);
    o = obs();
    total++;
    if (o !== 6'b100_100) begin
      bad++; $display("FAIL reset_initial got=%b want=100100", o);
    end
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'($urandom), 1'b1);
      o = obs();
      total++;
      if (o !== 6'b100_100) begin
        bad++; $display("FAIL reset_idle_%0d got=%b want=100100", i, o);
      end
    end
    // Abandon a frame mid-flight; outputs must drop without a clock edge.
    tick(1'b1, 4'b0000, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    o = obs();
    total++;
    if (o !== 6'b100_100) begin
      bad++; $display("FAIL reset_async got=%b want=100100", o);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'($urandom), 1'b1);
      o = obs();
      total++;
      if (o !== 6'b100_100) begin
        bad++; $display("FAIL reset_after_%0d got=%b want=100100", i, o);
      end
    end
  endtask

  task automatic test_frames();
    logic [3:0] w;
    logic [5:0] fm, fl, o, e;
    for (int n = 0; n < 7; n++) begin
      w  = (n == 0) ? 4'b1101 : 4'($urandom);
      fm = frame_bits(w, 1'b1);
      fl = frame_bits(w, 1'b0);
      // shift_en high together with load: must not advance past the start bit.
      tick(1'b1, w, 1'b1);
      o = obs();
      total++;
      if (o !== 6'b010_010) begin
        bad++; $display("FAIL frame%0d_start got=%b want=010010", n, o);
      end
      for (int s = 1; s < 6; s++) begin
        tick(1'b0, ~w, 1'b1);
        e = {fm[s], 1'b1, 1'b0, fl[s], 1'b1, 1'b0};
        o = obs();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL frame%0d_bit%0d word=%b got=%b want=%b", n, s, w, o, e);
        end
      end
      tick(1'b0, ~w, 1'b1);
      o = obs();
      total++;
      if (o !== 6'b101_101) begin
        bad++; $display("FAIL frame%0d_done got=%b want=101101", n, o);
      end
      tick(1'b0, ~w, 1'b1);
      o = obs();
      total++;
      if (o !== 6'b100_100) begin
        bad++; $display("FAIL frame%0d_idle got=%b want=100100", n, o);
      end
    end
  endtask

  task automatic test_load_ignored();
    logic [3:0] w;
    logic [5:0] fm, fl, o, e;
    w  = 4'b1010;
    fm = frame_bits(w, 1'b1);
    fl = frame_bits(w, 1'b0);
    tick(1'b1, w, 1'b1);
    o = obs();
    total++;
    if (o !== 6'b010_010) begin
      bad++; $display("FAIL ignore_start got=%b want=010010", o);
    end
    for (int s = 1; s < 6; s++) begin
      tick((s == 2) || (s == 5), 4'b0101, 1'b1);
      e = {fm[s], 1'b1, 1'b0, fl[s], 1'b1, 1'b0};
      o = obs();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL ignore_bit%0d got=%b want=%b", s, o, e);
      end
    end
    tick(1'b0, 4'b0101, 1'b1);
    o = obs();
    total++;
    if (o !== 6'b101_101) begin
      bad++; $display("FAIL ignore_done got=%b want=101101", o);
    end
    tick(1'b0, 4'b0101, 1'b1);
    o = obs();
    total++;
    if (o !== 6'b100_100) begin
      bad++; $display("FAIL ignore_idle got=%b want=100100", o);
    end
  endtask

  task automatic test_slow_shift();
    logic [3:0] w;
    logic [5:0] fm, fl, o, e;
    logic       sh;
    int         shifts;
    int         dones;
    w      = 4'($urandom);
    fm     = frame_bits(w, 1'b1);
    fl     = frame_bits(w, 1'b0);
    shifts = 0;
    dones  = 0;
    tick(1'b1, w, 1'b0);
    o = obs();
    total++;
    if (o !== 6'b010_010) begin
      bad++; $display("FAIL slow_start got=%b want=010010", o);
    end
    for (int c = 1; c <= 20; c++) begin
      sh = ((c % 3) == 0);
      tick(1'b0, 4'($urandom), sh);
      if (sh && shifts < 6) shifts++;
      if (shifts < 6)
        e = {fm[shifts], 1'b1, 1'b0, fl[shifts], 1'b1, 1'b0};
      else if (sh && c == 18)
        e = 6'b101_101;
      else
        e = 6'b100_100;
      o = obs();
      if (done_m) dones++;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL slow_c%0d got=%b want=%b", c, o, e);
      end
    end
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL slow_done_count got=%0d want=1", dones);
    end
  endtask

  task automatic test_loopback();
    logic [3:0] rx_m, rx_l;
    logic [5:0] o;
    tick(1'b1, 4'd0, 1'b1);
    o = obs();
    total++;
    if (o !== 6'b010_010) begin
      bad++; $display("FAIL loop_first_start got=%b want=010010", o);
    end
    for (int v = 0; v < 16; v++) begin
      rx_m = '0;
      rx_l = '0;
      for (int s = 1; s <= 4; s++) begin
        tick(1'b0, ~4'(v), 1'b1);
        rx_m = {rx_m[2:0], ser_m};
        rx_l = {ser_l, rx_l[3:1]};
      end
      tick(1'b0, ~4'(v), 1'b1);
      tick(1'b0, ~4'(v), 1'b1);
      o = obs();
      total++;
      if (o !== 6'b101_101) begin
        bad++; $display("FAIL loop%0d_done got=%b want=101101", v, o);
      end
      total++;
      if (rx_m !== 4'(v) || rx_l !== 4'(v)) begin
        bad++; $display("FAIL loop%0d_rx got msb=%b lsb=%b want=%b", v, rx_m, rx_l, 4'(v));
      end
      if (v < 15) begin
        // Load issued in the done cycle.
        tick(1'b1, 4'(v + 1), 1'b1);
        o = obs();
        total++;
        if (o !== 6'b010_010) begin
          bad++; $display("FAIL loop%0d_reload got=%b want=010010", v + 1, o);
        end
      end
    end
    tick(1'b0, 4'd0, 1'b1);
    o = obs();
    total++;
    if (o !== 6'b100_100) begin
      bad++; $display("FAIL loop_end_idle got=%b want=100100", o);
    end
  endtask

  initial begin
    n_rst    = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    par_in   = '0;
    test_reset();
    test_frames();
    test_load_ignored();
    test_slow_shift();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
